// File: rtl/ps2_port.sv
// ps2_port: bidirectional PS/2 port; rx frames -> byte FIFO, tx command bytes with inhibit/request/ack.
// Latency: raw line change -> filtered edge in 2+FILTER_LEN clk; FIFO push lands the cycle after the stop fall.
// Backpressure: rx_valid/rx_ready pop; a good frame arriving while the FIFO is full is dropped (rx_overflow).
// Ports: clk/reset (async, active low); ps2_clk_i/ps2_data_i raw lines, ps2_clk_oe/ps2_data_oe open-drain
// pulls; rx_data/rx_valid/rx_ready FIFO head, rx_err/rx_overflow pulses; tx_data/tx_valid/tx_ready command,
// tx_ack/tx_nack pulses; busy = either direction mid-transfer.
module ps2_port #(
  parameter int FILTER_LEN     = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int RX_TIMEOUT     = 2000,
  parameter int INHIBIT_CYCLES = 200,
  parameter int TX_TIMEOUT     = 30000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_err,
  output logic       rx_overflow,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_ack,
  output logic       tx_nack,
  output logic       busy
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int RTW = $clog2(RX_TIMEOUT + 1);
  localparam int TMX = (TX_TIMEOUT > INHIBIT_CYCLES) ? TX_TIMEOUT : INHIBIT_CYCLES;
  localparam int TCW = $clog2(TMX + 1);

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_PAR, R_STOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_INH, T_REQ, T_BITS, T_ACK, T_WAIT} tx_state_t;

  rx_state_t rx_state;
  tx_state_t tx_state;

  // ---------------- input conditioning ----------------
  logic [1:0] clk_sync, data_sync;
  logic       clk_f, data_f, fall;
  logic [3:0] clk_cnt, data_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_f     <= 1'b1;
      data_f    <= 1'b1;
      clk_cnt   <= '0;
      data_cnt  <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
      fall      <= 1'b0;
      // The count tracks consecutive samples that disagree with the filtered value.
      if (clk_sync[1] == clk_f) begin
        clk_cnt <= '0;
      end else if (clk_cnt == 4'(FILTER_LEN - 1)) begin
        clk_f   <= clk_sync[1];
        clk_cnt <= '0;
        fall    <= clk_f;  // old value 1 means this change is 1->0
      end else begin
        clk_cnt <= clk_cnt + 4'd1;
      end
      if (data_sync[1] == data_f) begin
        data_cnt <= '0;
      end else if (data_cnt == 4'(FILTER_LEN - 1)) begin
        data_f   <= data_sync[1];
        data_cnt <= '0;
      end else begin
        data_cnt <= data_cnt + 4'd1;
      end
    end
  end

  // ---------------- receive ----------------
  logic [7:0]     rx_shift;
  logic           rx_par;
  logic [2:0]     rx_bits;
  logic [RTW-1:0] rx_tcnt;
  logic           rx_fall, push, full, pop, wr;

  // Falls produced while we drive the bus are ours, not device data.
  assign rx_fall = fall & (tx_state == T_IDLE);
  assign push    = rx_fall & (rx_state == R_STOP) & data_f & (^{rx_shift, rx_par});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state    <= R_IDLE;
      rx_shift    <= '0;
      rx_par      <= 1'b0;
      rx_bits     <= '0;
      rx_tcnt     <= '0;
      rx_err      <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      rx_err      <= 1'b0;
      rx_overflow <= push & full & ~pop;
      if (rx_state == R_IDLE) begin
        rx_tcnt <= '0;
        if (rx_fall && !data_f) begin
          rx_state <= R_DATA;
          rx_bits  <= '0;
          rx_tcnt  <= RTW'(1);
        end
      end else if (rx_fall) begin
        // Counter starts at 1 so the error lands RX_TIMEOUT cycles after the fall strobe.
        rx_tcnt <= RTW'(1);
        case (rx_state)
          R_DATA: begin
            rx_shift <= {data_f, rx_shift[7:1]};
            rx_bits  <= rx_bits + 3'd1;
            if (rx_bits == 3'd7) rx_state <= R_PAR;
          end
          R_PAR: begin
            rx_par   <= data_f;
            rx_state <= R_STOP;
          end
          default: begin
            if (!(data_f && (^{rx_shift, rx_par}))) rx_err <= 1'b1;
            rx_state <= R_IDLE;
          end
        endcase
      end else if (rx_tcnt == RTW'(RX_TIMEOUT - 1)) begin
        rx_state <= R_IDLE;
        rx_err   <= 1'b1;
      end else begin
        rx_tcnt <= rx_tcnt + RTW'(1);
      end
    end
  end

  // ---------------- rx FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign rx_valid = (count != '0);
  assign full     = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop      = rx_valid & rx_ready;
  assign wr       = push & (~full | pop);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- transmit ----------------
  logic [8:0]     tx_shift;  // {parity, data}, shifted out LSB first
  logic [3:0]     tx_bits;
  logic [TCW-1:0] tx_cnt;
  logic           rdy_en;     // keeps tx_ready low while reset is asserted

  assign tx_ready = rdy_en & (tx_state == T_IDLE) & (rx_state == R_IDLE);
  assign busy     = (rx_state != R_IDLE) | (tx_state != T_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state    <= T_IDLE;
      tx_shift    <= '0;
      tx_bits     <= '0;
      tx_cnt      <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ack      <= 1'b0;
      tx_nack     <= 1'b0;
      rdy_en      <= 1'b0;
    end else begin
      tx_ack  <= 1'b0;
      tx_nack <= 1'b0;
      rdy_en  <= 1'b1;
      case (tx_state)
        T_IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_shift   <= {~(^tx_data), tx_data};
            tx_cnt     <= '0;
            ps2_clk_oe <= 1'b1;
            tx_state   <= T_INH;
          end
        end
        T_INH: begin
          if (tx_cnt == TCW'(INHIBIT_CYCLES - 1)) begin
            // Request-to-send: start bit low, clock handed back to the device.
            tx_cnt      <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            tx_bits     <= '0;
            tx_state    <= T_REQ;
          end else begin
            tx_cnt <= tx_cnt + TCW'(1);
          end
        end
        default: begin
          if (tx_cnt == TCW'(TX_TIMEOUT - 1)) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_nack     <= 1'b1;
            tx_state    <= T_IDLE;
          end else begin
            tx_cnt <= tx_cnt + TCW'(1);
            case (tx_state)
              T_REQ: tx_state <= T_BITS;
              T_BITS: begin
                if (fall) begin
                  if (tx_bits == 4'd9) begin
                    ps2_data_oe <= 1'b0;  // stop bit: line released high
                    tx_state    <= T_ACK;
                  end else begin
                    ps2_data_oe <= ~tx_shift[0];
                    tx_shift    <= {1'b0, tx_shift[8:1]};
                    tx_bits     <= tx_bits + 4'd1;
                  end
                end
              end
              T_ACK: begin
                if (fall) begin
                  if (!data_f) tx_ack  <= 1'b1;
                  else         tx_nack <= 1'b1;
                  tx_state <= T_WAIT;
                end
              end
              T_WAIT:  if (clk_f && data_f) tx_state <= T_IDLE;
              default: tx_state <= T_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
